pe_conv_seq: RTL and testbench



---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_tap_cnt.sv | 78 +++++++
 rtl/pe_conv_seq.sv | 137 +++++++++++++
 tb/tb_pe_conv_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE convolution sequencer: geometry constants,
// controller state encoding and the select-packing helper.
package pe_pkg;

  localparam int IMG  = 4;
  localparam int K    = 3;
  localparam int NTAP = K * K;
  localparam int ODIM = IMG - K + 1;
  localparam int NOUT = ODIM * ODIM;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAP,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Both PE selects are two 2-bit indices packed high/low.
  function automatic logic [3:0] pack_sel(input logic [1:0] hi, input logic [1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/pe_tap_cnt.sv
// Nested kernel-tap (kr/kc) and output-window (orow/ocol) counters with wrap
// flags; both wrap back to zero so the next pass starts from a clean origin.
module pe_tap_cnt
  import pe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       adv_tap_i,
  input  logic       adv_win_i,
  output logic [1:0] kr_o,
  output logic [1:0] kc_o,
  output logic [1:0] orow_o,
  output logic [1:0] ocol_o,
  output logic       tap_last_o,
  output logic       win_last_o
);

  localparam logic [1:0] KMAX = 2'(K - 1);
  localparam logic [1:0] OMAX = 2'(ODIM - 1);

  logic [1:0] kr_q, kr_d;
  logic [1:0] kc_q, kc_d;
  logic [1:0] orow_q, orow_d;
  logic [1:0] ocol_q, ocol_d;

  always_comb begin
    kr_d   = kr_q;
    kc_d   = kc_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    if (clear_i) begin
      kr_d   = '0;
      kc_d   = '0;
      orow_d = '0;
      ocol_d = '0;
    end else begin
      if (adv_tap_i) begin
        if (kc_q == KMAX) begin
          kc_d = '0;
          kr_d = (kr_q == KMAX) ? 2'd0 : kr_q + 2'd1;
        end else begin
          kc_d = kc_q + 2'd1;
        end
      end
      if (adv_win_i) begin
        if (ocol_q == OMAX) begin
          ocol_d = '0;
          orow_d = (orow_q == OMAX) ? 2'd0 : orow_q + 2'd1;
        end else begin
          ocol_d = ocol_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kr_q   <= '0;
      kc_q   <= '0;
      orow_q <= '0;
      ocol_q <= '0;
    end else begin
      kr_q   <= kr_d;
      kc_q   <= kc_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
    end
  end

  assign kr_o       = kr_q;
  assign kc_o       = kc_q;
  assign orow_o     = orow_q;
  assign ocol_o     = ocol_q;
  assign tap_last_o = (kr_q == KMAX) && (kc_q == KMAX);
  assign win_last_o = (orow_q == OMAX) && (ocol_q == OMAX);

endmodule

// File: rtl/pe_conv_seq.sv
// Sequencer for pe_single_module: walks every kernel tap of every valid output
// window, then captures the PE accumulator into the c11..c22 result file.
module pe_conv_seq
  import pe_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [3:0]    pe_s0,
  output logic [3:0]    pe_s1,
  output logic          pe_init,
  output logic          pe_rst,
  output logic          pe_preset,
  input  logic [DW-1:0] pe_out,
  output logic [DW-1:0] c11,
  output logic [DW-1:0] c12,
  output logic [DW-1:0] c21,
  output logic [DW-1:0] c22,
  output logic          result_valid
);

  state_e state_q, state_d;

  logic          cnt_clear, adv_tap, adv_win, capture, start_acc;
  logic [1:0]    kr, kc, orow, ocol;
  logic          tap_last, win_last;
  logic [1:0]    win;
  logic [1:0]    frow, fcol;
  logic [DW-1:0] c_q [4];
  logic          valid_q;

  pe_tap_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (cnt_clear),
    .adv_tap_i  (adv_tap),
    .adv_win_i  (adv_win),
    .kr_o       (kr),
    .kc_o       (kc),
    .orow_o     (orow),
    .ocol_o     (ocol),
    .tap_last_o (tap_last),
    .win_last_o (win_last)
  );

  assign win  = 2'(orow * 2'(ODIM) + ocol);
  assign frow = orow + kr;
  assign fcol = ocol + kc;

  // Moore outputs: the PE sees a cleared accumulator in every non-TAP state,
  // and FLUSH clears it at the same edge its sum is captured.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    adv_tap   = 1'b0;
    adv_win   = 1'b0;
    capture   = 1'b0;
    start_acc = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pe_rst    = 1'b1;
    pe_init   = 1'b0;
    pe_s0     = '0;
    pe_s1     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_TAP;
          cnt_clear = 1'b1;
          start_acc = 1'b1;
        end
      end
      ST_TAP: begin
        busy    = 1'b1;
        pe_rst  = 1'b0;
        pe_s0   = pack_sel(fcol, frow);
        pe_s1   = pack_sel(kr, kc);
        adv_tap = 1'b1;
        if (tap_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy    = 1'b1;
        pe_init = 1'b1;
        capture = 1'b1;
        if (win_last) begin
          state_d = ST_DONE;
        end else begin
          adv_win = 1'b1;
          state_d = ST_TAP;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d   = ST_TAP;
          cnt_clear = 1'b1;
          start_acc = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) c_q[i] <= '0;
    end else if (capture) begin
      c_q[win] <= pe_out;
    end
  end

  // Valid only once the last window lands; a new run invalidates the old set.
  always_ff @(posedge clk) begin
    if (rst)                      valid_q <= 1'b0;
    else if (start_acc)           valid_q <= 1'b0;
    else if (capture && win_last) valid_q <= 1'b1;
  end

  assign pe_preset    = 1'b0;
  assign c11          = c_q[0];
  assign c12          = c_q[1];
  assign c21          = c_q[2];
  assign c22          = c_q[3];
  assign result_valid = valid_q;

endmodule

// File: tb/tb_pe_conv_seq.sv
// Directed bench for pe_conv_seq with a behavioural PE accumulator model
// driven by the sequencer's selects.
module tb_pe_conv_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done;
  logic [3:0] peS0, peS1;
  logic       peInit, peRst, pePreset;
  logic [7:0] peOut;
  logic [7:0] c11, c12, c21, c22;
  logic       resultValid;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] featMap [4][4];
  logic [7:0] kern [4][4];
  logic [7:0] acc;

  logic [3:0] expS0 [9];
  logic [3:0] expS1 [9];

  always #5 clk = ~clk;

  pe_conv_seq #(.DW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .pe_s0        (peS0),
    .pe_s1        (peS1),
    .pe_init      (peInit),
    .pe_rst       (peRst),
    .pe_preset    (pePreset),
    .pe_out       (peOut),
    .c11          (c11),
    .c12          (c12),
    .c21          (c21),
    .c22          (c22),
    .result_valid (resultValid)
  );

  // PE stand-in: pe_s0 = {col,row} into the feature map, pe_s1 = {krow,kcol}.
  always @(posedge clk) begin
    if (peRst) acc <= 8'd0;
    else       acc <= acc + featMap[peS0[1:0]][peS0[3:2]] * kern[peS1[3:2]][peS1[1:0]];
  end
  assign peOut = acc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, " c11"}, 32'(c11), 32'd177);
    checkOutput({tag, " c12"}, 32'(c12), 32'd235);
    checkOutput({tag, " c21"}, 32'(c21), 32'd222);
    checkOutput({tag, " c22"}, 32'(c22), 32'd18);
    checkOutput({tag, " valid"}, 32'(resultValid), 32'd1);
  endtask

  // One start pulse, optional re-pulse at cycle pulseAt, optional c12 select trace.
  task automatic applyStimulus(input string tag, input int pulseAt, input bit trace);
    int n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (!done && n < 60) begin
      if (trace && n >= 11 && n <= 19) begin
        checkOutput($sformatf("%s s0 tap%0d", tag, n - 11), 32'(peS0), 32'(expS0[n - 11]));
        checkOutput($sformatf("%s s1 tap%0d", tag, n - 11), 32'(peS1), 32'(expS1[n - 11]));
      end
      if (trace && n == 20) begin
        checkOutput({tag, " flush init"}, 32'(peInit), 32'd1);
        checkOutput({tag, " flush rst"}, 32'(peRst), 32'd1);
      end
      if (n == 5) checkOutput({tag, " busy mid"}, 32'(busy), 32'd1);
      start = (n == pulseAt);
      @(negedge clk); n++;
    end
    start = 1'b0;
    checkOutput({tag, " done cycle"}, 32'(n), 32'd41);
    checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
    checkResults(tag);
  endtask

  initial begin
    int n;
    int doneCount;

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        featMap[r][c] = 8'd0;
        kern[r][c] = 8'd0;
      end
    featMap[0][0] = 1; featMap[0][1] = 2; featMap[0][2] = 3; featMap[0][3] = 4;
    featMap[1][0] = 2; featMap[1][1] = 3; featMap[1][2] = 4; featMap[1][3] = 5;
    featMap[2][0] = 3; featMap[2][1] = 4; featMap[2][2] = 5; featMap[2][3] = 5;
    featMap[3][0] = 3; featMap[3][1] = 4; featMap[3][2] = 5; featMap[3][3] = 5;
    kern[0][0] = 9; kern[0][1] = 8; kern[0][2] = 7;
    kern[1][0] = 8; kern[1][1] = 7; kern[1][2] = 6;
    kern[2][0] = 7; kern[2][1] = 6; kern[2][2] = 5;
    expS0 = '{4'b0100, 4'b1000, 4'b1100, 4'b0101, 4'b1001, 4'b1101, 4'b0110, 4'b1010, 4'b1110};
    expS1 = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1010};

    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("reset c11", 32'(c11), 32'd0);
    checkOutput("reset c22", 32'(c22), 32'd0);
    checkOutput("reset valid", 32'(resultValid), 32'd0);

    // Idle: {busy,done,pe_rst,pe_s0,pe_s1,pe_preset,pe_init} must stay 0_0_1_0000_0000_0_0.
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("idle outputs cyc%0d", i),
                  32'({busy, done, peRst, peS0, peS1, pePreset, peInit}),
                  32'(13'b0_0_1_0000_0000_0_0));
      @(negedge clk);
    end

    applyStimulus("run1", 0, 1'b0);
    applyStimulus("trace", 0, 1'b1);
    applyStimulus("restart ignored", 23, 1'b0);

    // Reset during the 5th tap of window c12 (cycle 15).
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (n < 15) begin @(negedge clk); n++; end
    checkOutput("abort pre s0", 32'(peS0), 32'(4'b1001));
    checkOutput("abort pre c11", 32'(c11), 32'd177);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort pe_rst", 32'(peRst), 32'd1);
    checkOutput("abort s0", 32'(peS0), 32'd0);
    checkOutput("abort c11", 32'(c11), 32'd0);
    checkOutput("abort c12", 32'(c12), 32'd0);
    checkOutput("abort valid", 32'(resultValid), 32'd0);
    applyStimulus("after abort", 0, 1'b0);

    // Start held high: back-to-back runs, DONE straight into TAP.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk); n = 1; doneCount = 0;
    while (doneCount < 3 && n < 200) begin
      if (done) begin
        doneCount++;
        checkOutput($sformatf("b2b done%0d cycle", doneCount), 32'(n), 32'(41 * doneCount));
        checkResults($sformatf("b2b run%0d", doneCount));
        if (doneCount == 3) start = 1'b0;
      end
      if (n == 42) begin
        checkOutput("b2b valid drop", 32'(resultValid), 32'd0);
        checkOutput("b2b busy restart", 32'(busy), 32'd1);
      end
      if (doneCount < 3) begin @(negedge clk); n++; end
    end
    checkOutput("b2b done count", 32'(doneCount), 32'd3);
    @(negedge clk);
    checkOutput("b2b idle busy", 32'(busy), 32'd0);
    checkOutput("b2b idle valid", 32'(resultValid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
